// File: rtl/decode_issue_ctrl_if.sv
// Fetch / decoder / execute / writeback signal bundle for decode_issue_ctrl.
// slave is the controller's view; master is the surrounding pipeline's view.
interface decode_issue_ctrl_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [31:0] dec_instr;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_rs1_valid;
  logic        dec_rs2_valid;
  logic        dec_rd_valid;

  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;

  logic        wb_valid;
  logic [4:0]  wb_rd;

  logic        flush;
  logic [31:0] stall_cycles;

  modport slave (
    input  if_valid, if_instr, if_pc,
    input  dec_rs1, dec_rs2, dec_rd, dec_rs1_valid, dec_rs2_valid, dec_rd_valid,
    input  ex_ready, wb_valid, wb_rd, flush,
    output if_ready, dec_instr, ex_valid, ex_instr, ex_pc, stall_cycles
  );

  modport master (
    output if_valid, if_instr, if_pc,
    output dec_rs1, dec_rs2, dec_rd, dec_rs1_valid, dec_rs2_valid, dec_rd_valid,
    output ex_ready, wb_valid, wb_rd, flush,
    input  if_ready, dec_instr, ex_valid, ex_instr, ex_pc, stall_cycles
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: one-entry holding register, register scoreboard, issue gating.
// Define WB_BYPASS_EN to let a same-cycle writeback release a waiting instruction.
module decode_issue_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
  input logic                clk,
  input logic                rst_n,
  decode_issue_ctrl_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } id_state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  id_state_t   id_state_reg, id_state_next;
  logic [31:0] id_instr_reg, id_instr_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:1] pending_reg, pending_next;
  logic [3:0]  out_cnt_reg, out_cnt_next;
  logic [31:0] stall_cycles_reg;

  logic [31:1] set_mask;
  logic [31:1] clr_mask;
  logic [31:0] pend_full;
  logic [31:0] pend_view;
  logic [3:0]  cnt_view;

  logic id_valid;
  logic rd_write;
  logic wb_clear;
  logic cnt_inc;
  logic cnt_dec;
  logic hazard;
  logic ex_valid;
  logic issue;
  logic if_ready;
  logic accept;

  assign id_valid  = (id_state_reg == HELD);
  assign rd_write  = bus.dec_rd_valid && (bus.dec_rd != 5'd0);
  assign pend_full = {pending_reg, 1'b0};

  // Writebacks only count when they retire a register that is actually pending.
  assign wb_clear = bus.wb_valid && (bus.wb_rd != 5'd0) && pend_full[bus.wb_rd];
  assign cnt_inc  = issue && rd_write;
  assign cnt_dec  = wb_clear && (out_cnt_reg != 4'd0);

  for (genvar gi = 1; gi < 32; gi++) begin : g_sb_mask
    assign set_mask[gi] = cnt_inc && (bus.dec_rd == 5'(gi));
    assign clr_mask[gi] = wb_clear && (bus.wb_rd == 5'(gi));
  end

`ifdef WB_BYPASS_EN
  assign pend_view = pend_full & ~{clr_mask, 1'b0};
  assign cnt_view  = out_cnt_reg - {3'd0, cnt_dec};
`else
  assign pend_view = pend_full;
  assign cnt_view  = out_cnt_reg;
`endif

  assign hazard = (bus.dec_rs1_valid && (bus.dec_rs1 != 5'd0) && pend_view[bus.dec_rs1])
               || (bus.dec_rs2_valid && (bus.dec_rs2 != 5'd0) && pend_view[bus.dec_rs2])
               || (rd_write && pend_view[bus.dec_rd])
               || (rd_write && (cnt_view == MAX_CNT));

  assign ex_valid = id_valid && !hazard && !bus.flush;
  assign issue    = ex_valid && bus.ex_ready;
  assign if_ready = !bus.flush && (!id_valid || issue);
  assign accept   = bus.if_valid && if_ready;

  // An empty holding register presents a NOP so the decoder never sees stale bits.
  assign bus.dec_instr    = id_valid ? id_instr_reg : NOP_INSTR;
  assign bus.ex_instr     = id_valid ? id_instr_reg : NOP_INSTR;
  assign bus.ex_pc        = id_pc_reg;
  assign bus.ex_valid     = ex_valid;
  assign bus.if_ready     = if_ready;
  assign bus.stall_cycles = stall_cycles_reg;

  always_comb begin
    id_state_next = id_state_reg;
    id_instr_next = id_instr_reg;
    id_pc_next    = id_pc_reg;
    if (bus.flush) begin
      id_state_next = EMPTY;
    end else if (accept) begin
      id_state_next = HELD;
      id_instr_next = bus.if_instr;
      id_pc_next    = bus.if_pc;
    end else if (issue) begin
      id_state_next = EMPTY;
    end
  end

  // Set beats clear when issue and writeback hit the same register.
  always_comb begin
    pending_next = (pending_reg & ~clr_mask) | set_mask;
    out_cnt_next = out_cnt_reg;
    if (cnt_inc && !cnt_dec) begin
      out_cnt_next = out_cnt_reg + 4'd1;
    end else if (!cnt_inc && cnt_dec) begin
      out_cnt_next = out_cnt_reg - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_state_reg <= EMPTY;
      id_instr_reg <= NOP_INSTR;
      id_pc_reg    <= 32'd0;
    end else begin
      id_state_reg <= id_state_next;
      id_instr_reg <= id_instr_next;
      id_pc_reg    <= id_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg      <= '0;
      out_cnt_reg      <= 4'd0;
      stall_cycles_reg <= 32'd0;
    end else begin
      pending_reg <= pending_next;
      out_cnt_reg <= out_cnt_next;
      if (id_valid && hazard && !bus.flush) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: per-cycle vector table plus scoreboard corner sequences.
// Expectations branch on WB_BYPASS_EN where same-cycle writeback release changes timing.
module tb_decode_issue_ctrl;

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] ADDI12   = 32'h00a00613;
  localparam logic [31:0] LW13     = 32'h00002683;
  localparam logic [31:0] ADD14    = 32'h00e68733;
  localparam logic [31:0] I1       = 32'h00100093;
  localparam logic [31:0] I2       = 32'h00200113;
  localparam logic [31:0] I3       = 32'h00300193;
  localparam logic [31:0] I4       = 32'h00400213;
  localparam logic [31:0] I5       = 32'h00500293;
  localparam logic [31:0] ADDI14Z  = 32'h00000713;
  localparam logic [31:0] BEQ      = 32'h00000063;
  localparam logic [31:0] PC_OFS   = 32'h10000000;

  typedef struct {
    logic        ifv;
    logic [31:0] instr;
    logic        exr;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        exp_ev;
    logic        exp_ifr;
    logic [31:0] exp_exi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_stall;
  vec_t tbl[$];

  decode_issue_ctrl_if bus();

  decode_issue_ctrl #(.MAX_OUTSTANDING(4), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Minimal RV32I field decoder standing in for the real decoder.
  always_comb begin
    bus.dec_rs1       = bus.dec_instr[19:15];
    bus.dec_rs2       = bus.dec_instr[24:20];
    bus.dec_rd        = bus.dec_instr[11:7];
    bus.dec_rs1_valid = 1'b0;
    bus.dec_rs2_valid = 1'b0;
    bus.dec_rd_valid  = 1'b0;
    case (bus.dec_instr[6:0])
      7'b0010011, 7'b0000011: begin
        bus.dec_rs1_valid = 1'b1;
        bus.dec_rd_valid  = 1'b1;
      end
      7'b0110011: begin
        bus.dec_rs1_valid = 1'b1;
        bus.dec_rs2_valid = 1'b1;
        bus.dec_rd_valid  = 1'b1;
      end
      7'b1100011, 7'b0100011: begin
        bus.dec_rs1_valid = 1'b1;
        bus.dec_rs2_valid = 1'b1;
      end
      7'b0110111: bus.dec_rd_valid = 1'b1;
      default: ;
    endcase
  end

  function automatic vec_t mk(logic ifv, logic [31:0] instr, logic exr, logic wbv,
                              logic [4:0] wbrd, logic fl, logic ev, logic ifr,
                              logic [31:0] exi);
    vec_t v;
    v.ifv = ifv; v.instr = instr; v.exr = exr; v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
    v.exp_ev = ev; v.exp_ifr = ifr; v.exp_exi = exi;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  task automatic drive(logic ifv, logic [31:0] instr, logic exr, logic wbv,
                       logic [4:0] wbrd, logic fl);
    bus.if_valid = ifv;
    bus.if_instr = instr;
    bus.if_pc    = instr + PC_OFS;
    bus.ex_ready = exr;
    bus.wb_valid = wbv;
    bus.wb_rd    = wbrd;
    bus.flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].ifv, tbl[i].instr, tbl[i].exr, tbl[i].wbv, tbl[i].wbrd, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("row%0d_ex_valid", i), 32'(bus.ex_valid), 32'(tbl[i].exp_ev));
      chk($sformatf("row%0d_if_ready", i), 32'(bus.if_ready), 32'(tbl[i].exp_ifr));
      chk($sformatf("row%0d_ex_instr", i), bus.ex_instr, tbl[i].exp_exi);
      if (tbl[i].exp_ev)
        chk($sformatf("row%0d_ex_pc", i), bus.ex_pc, tbl[i].exp_exi + PC_OFS);
      tick();
    end
  endtask

  task automatic do_reset(string tag);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_ex_valid"}, 32'(bus.ex_valid), 32'd0);
    chk({tag, "_if_ready"}, 32'(bus.if_ready), 32'd1);
    chk({tag, "_ex_instr"}, bus.ex_instr, NOP);
    chk({tag, "_dec_instr"}, bus.dec_instr, NOP);
    chk({tag, "_ex_pc"}, bus.ex_pc, 32'd0);
    chk({tag, "_stall"}, bus.stall_cycles, 32'd0);
    chk({tag, "_out_cnt"}, 32'(dut.out_cnt_reg), 32'd0);
    chk({tag, "_pending"}, {dut.pending_reg, 1'b0}, 32'd0);
    tick();
  endtask

  initial begin
    // Segment A (rows 0-7): back-to-back issue, then load-use stall for 5 cycles.
    tbl.push_back(mk(1, ADDI12, 1, 0, 0, 0, 0, 1, NOP));
    tbl.push_back(mk(1, LW13,   1, 0, 0, 0, 1, 1, ADDI12));
    tbl.push_back(mk(1, ADD14,  1, 0, 0, 0, 1, 1, LW13));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1, I1, 1, 0, 0, 0, 0, 0, ADD14));
    // Segment B (rows 8-14): four rd-writers fill the budget, fifth waits.
    tbl.push_back(mk(1, I1, 1, 0, 0, 0, 0, 1, NOP));
    tbl.push_back(mk(1, I2, 1, 0, 0, 0, 1, 1, I1));
    tbl.push_back(mk(1, I3, 1, 0, 0, 0, 1, 1, I2));
    tbl.push_back(mk(1, I4, 1, 0, 0, 0, 1, 1, I3));
    tbl.push_back(mk(1, I5, 1, 0, 0, 0, 1, 1, I4));
    tbl.push_back(mk(0, 0,  1, 0, 0, 0, 0, 0, I5));
    tbl.push_back(mk(0, 0,  1, 0, 0, 0, 0, 0, I5));
    // Segment C (rows 15-20): flush of a stalled instruction, then beq and a budget stall.
    tbl.push_back(mk(1, I2,      1, 0, 0, 0, 0, 1, NOP));
    tbl.push_back(mk(0, 0,       1, 0, 0, 0, 0, 0, I2));
    tbl.push_back(mk(1, I1,      1, 0, 0, 1, 0, 0, I2));
    tbl.push_back(mk(1, BEQ,     1, 0, 0, 0, 0, 1, NOP));
    tbl.push_back(mk(1, ADDI14Z, 1, 0, 0, 0, 1, 1, BEQ));
    tbl.push_back(mk(0, 0,       1, 0, 0, 0, 0, 0, ADDI14Z));
    // Segment D (rows 21-35): stream of 8 stores, ex_ready backpressure, issue+wb overlap.
    tbl.push_back(mk(1, 32'h00002023, 1, 0, 0, 0, 0, 1, NOP));
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(1, 32'h00002023 | (32'(k) << 7), 1, 0, 0, 0, 1, 1,
                       32'h00002023 | (32'(k - 1) << 7)));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, I1, 0, 0, 0, 0, 1, 0, 32'h000023a3));
    tbl.push_back(mk(1, I1, 1, 0, 0, 0, 1, 1, 32'h000023a3));
    tbl.push_back(mk(1, I2, 1, 0, 0, 0, 1, 1, I1));
    tbl.push_back(mk(0, 0,  1, 1, 1, 0, 1, 1, I2));
    tbl.push_back(mk(0, 0,  1, 0, 0, 0, 0, 1, NOP));

    do_reset("reset0");

    run_rows(0, 7);
    chk("A_stall", bus.stall_cycles, 32'd5);
    chk("A_out_cnt", 32'(dut.out_cnt_reg), 32'd2);
    chk("A_pending", {dut.pending_reg, 1'b0}, 32'h00003000);

    // Writeback of x13 releases the dependent add.
    drive(0, 0, 1, 1, 5'd13, 0);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("wb13_ex_valid", 32'(bus.ex_valid), 32'd1);
    exp_stall = 5;
`else
    chk("wb13_ex_valid", 32'(bus.ex_valid), 32'd0);
    tick();
    drive(0, 0, 1, 0, 5'd0, 0);
    @(negedge clk);
    chk("wb13_next_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("wb13_next_ex_instr", bus.ex_instr, ADD14);
    exp_stall = 6;
`endif
    tick();
    drive(0, 0, 1, 0, 5'd0, 0);
    @(negedge clk);
    chk("wb13_after_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("wb13_out_cnt", 32'(dut.out_cnt_reg), 32'd2);
    chk("wb13_pending", {dut.pending_reg, 1'b0}, 32'h00005000);
    chk("wb13_stall", bus.stall_cycles, 32'(exp_stall));

    // Hold a WAW-stalled addi x12, then reset mid-operation.
    drive(1, ADDI12, 1, 0, 5'd0, 0);
    tick();
    drive(0, 0, 1, 0, 5'd0, 0);
    @(negedge clk);
    chk("held_before_reset", 32'(bus.ex_valid), 32'd0);
    do_reset("reset1");

    run_rows(8, 14);
    chk("B_out_cnt", 32'(dut.out_cnt_reg), 32'd4);
    chk("B_stall", bus.stall_cycles, 32'd2);

    // Writeback of x1 frees one budget slot for the waiting x5 writer.
    drive(0, 0, 1, 1, 5'd1, 0);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("wb1_ex_valid", 32'(bus.ex_valid), 32'd1);
    exp_stall = 2;
`else
    chk("wb1_ex_valid", 32'(bus.ex_valid), 32'd0);
    tick();
    drive(0, 0, 1, 0, 5'd0, 0);
    @(negedge clk);
    chk("wb1_next_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("wb1_next_ex_instr", bus.ex_instr, I5);
    exp_stall = 3;
`endif
    tick();
    drive(0, 0, 1, 0, 5'd0, 0);
    chk("wb1_out_cnt", 32'(dut.out_cnt_reg), 32'd4);
    chk("wb1_pending", {dut.pending_reg, 1'b0}, 32'h0000003c);

    run_rows(15, 20);
    exp_stall += 2;
    chk("C_out_cnt", 32'(dut.out_cnt_reg), 32'd4);
    chk("C_pending", {dut.pending_reg, 1'b0}, 32'h0000003c);
    chk("C_stall", bus.stall_cycles, 32'(exp_stall));

    // wb to x0 and to a non-pending register are ignored.
    drive(0, 0, 1, 1, 5'd0, 0);
    @(negedge clk);
    chk("wbx0_ex_valid", 32'(bus.ex_valid), 32'd0);
    tick();
    chk("wbx0_out_cnt", 32'(dut.out_cnt_reg), 32'd4);
    drive(0, 0, 1, 1, 5'd1, 0);
    @(negedge clk);
    chk("wbnp_ex_valid", 32'(bus.ex_valid), 32'd0);
    tick();
    chk("wbnp_out_cnt", 32'(dut.out_cnt_reg), 32'd4);
    chk("wbnp_pending", {dut.pending_reg, 1'b0}, 32'h0000003c);
    drive(0, 0, 0, 1, 5'd3, 0);
    @(negedge clk);
    chk("wb3_if_ready", 32'(bus.if_ready), 32'd0);
    tick();
    chk("wb3_out_cnt", 32'(dut.out_cnt_reg), 32'd3);
    drive(0, 0, 1, 0, 5'd0, 0);
    @(negedge clk);
    chk("x14_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("x14_ex_instr", bus.ex_instr, ADDI14Z);
    tick();
    chk("x14_out_cnt", 32'(dut.out_cnt_reg), 32'd4);
    chk("x14_pending", {dut.pending_reg, 1'b0}, 32'h00004034);

    do_reset("reset2");

    run_rows(21, 35);
    chk("D_out_cnt", 32'(dut.out_cnt_reg), 32'd1);
    chk("D_pending", {dut.pending_reg, 1'b0}, 32'h00000004);
    chk("D_stall", bus.stall_cycles, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Decode/issue controller sitting between fetch and execute in the synapse32 core.
- Holds one fetched instruction in a decode holding register and drives it into the combinational decoder.
- Uses the decoder's register-valid flags to check a register scoreboard, and issues to execute only when the instruction is free of RAW/WAW hazards and the outstanding-write budget allows.
- Handles fetch and execute valid/ready handshakes and branch flush.

Parameters:
- MAX_OUTSTANDING, 4, max issued rd-writing instructions not yet written back (1..15).
- NOP_INSTR, 32'h00000013, value driven on dec_instr/ex_instr when the holding register is empty or in reset.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- if_valid  in  1  fetch presents instruction
- if_ready  out  1  controller can accept
- if_instr  in  32  fetched instruction
- if_pc  in  32  its PC
- dec_instr  out  32  instruction driven to decoder
- dec_rs1  in  5  decoder rs1 index
- dec_rs2  in  5  decoder rs2 index
- dec_rd  in  5  decoder rd index
- dec_rs1_valid  in  1  decoder: rs1 used
- dec_rs2_valid  in  1  decoder: rs2 used
- dec_rd_valid  in  1  decoder: rd written
- ex_valid  out  1  instruction offered to execute
- ex_ready  in  1  execute accepts
- ex_instr  out  32  issued instruction
- ex_pc  out  32  issued PC
- wb_valid  in  1  writeback completes
- wb_rd  in  5  writeback destination
- flush  in  1  branch redirect, kill held instruction
- stall_cycles  out  32  perf counter, hazard-stall cycles

Behaviour:
- State: id_valid (EMPTY=0 / HELD=1), id_instr, id_pc, pending[31:1], out_cnt.
- Reset (rst_n=0 at edge):
  - id_valid=0; id_instr=NOP_INSTR; id_pc=0.
  - pending=0; out_cnt=0; stall_cycles=0.
  - Outputs follow: ex_valid=0, if_ready=1 from the first cycle after reset.
  - Reset mid-operation discards the held instruction and all pending bits.
- dec_instr=id_instr; ex_instr=id_instr; ex_pc=id_pc (combinational from the holding register).
- hazard = (rs1_valid & rs1≠0 & pending[rs1]) | (rs2_valid & rs2≠0 & pending[rs2]) | (rd_valid & rd≠0 & pending[rd]) | (rd_valid & rd≠0 & out_cnt==MAX_OUTSTANDING).
  - The rd≠0 qualifier applies to all source and destination checks; x0 is never pending.
- ex_valid = id_valid & ~hazard & ~flush. issue = ex_valid & ex_ready.
- if_ready = ~flush & (~id_valid | issue). accept = if_valid & if_ready.
- Holding register update, priority order:
  - flush: id_valid←0.
  - accept: load if_instr/if_pc, id_valid←1.
  - issue without accept: id_valid←0.
  - otherwise: hold.
- Accept and issue may occur in the same cycle (back-to-back throughput 1/cycle).
- Latency: instruction accepted at edge N is offered on ex_valid during cycle N+1 if hazard-free.
- Scoreboard:
  - issue with rd_valid & rd≠0 sets pending[rd] and increments out_cnt.
  - wb_valid & wb_rd≠0 clears pending[wb_rd] and decrements out_cnt.
  - Issue and writeback in the same cycle leave out_cnt unchanged.
  - If issue sets and wb clears the same index in one cycle, set wins.
  - wb to x0 or to a non-pending register is ignored; out_cnt does not change.
  - out_cnt never wraps: decrement at 0 is suppressed.
- Flush does not modify pending/out_cnt; in-flight writers still write back.
- Every issued rd-writing instruction must produce exactly one wb_valid pulse.
- stall_cycles increments (wrapping at 2^32) each cycle with id_valid & hazard & ~flush.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Hazard evaluation uses pending & ~wb_clear_mask, so an instruction waiting on register X issues in the same cycle that wb_rd=X writes back.
  - out_cnt==MAX check also credits a same-cycle writeback.
- Undefined:
  - Hazard uses the registered pending/out_cnt only; a dependent instruction issues one cycle after the writeback cycle.

Test Plan:
- Reset, then feed 0x00a00613 (addi x12,x0,10) with ex_ready=1 -> ex_valid high the cycle after accept, ex_instr=0x00a00613, pending[12]=1, out_cnt=1.
- lw x13 0x00002683 issued, then add 0x00e68733, wb withheld 5 cycles -> ex_valid=0 and if_ready=0 for 5 cycles, stall_cycles=5. wb_rd=13 -> add issues next cycle, or same cycle with WB_BYPASS_EN.
- Issue 4 rd-writers to x1..x4 with no wb, then 5th to x5 -> 5th stalls at out_cnt=4. wb_rd=1 releases it; simultaneous issue+wb keeps out_cnt=4.
- Held stalled instruction plus flush=1 for one cycle -> ex_valid=0 during flush, id_valid=0 after, pending bits unchanged, next fetch accepted the following cycle.
- Stream 8 independent instructions, if_valid=1, ex_ready=1 -> one issue per cycle. ex_ready=0 for 3 cycles -> if_ready=0 and ex_instr held stable.
- Issue 0x00000713 (addi x14,x0,0) and 0x00000063 (beq, no rd) -> x14 pending. beq sets nothing; wb_rd=0 ignored, out_cnt unchanged.
